// File: rtl/power_switch_sequencer.sv
// rtl/power_switch_sequencer.sv - segmented power-switch on/off sequencer (optional PSW_ACK_EN: per-segment acknowledge)
module power_switch_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int DLY_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sleep_req,
  input  logic [DLY_W-1:0]      stage_delay,
`ifdef PSW_ACK_EN
  input  logic [NUM_STAGES-1:0] sw_ack,
`endif
  output logic [NUM_STAGES-1:0] switch_en,
  output logic                  power_good,
  output logic                  busy,
  output logic [1:0]            state
);

  localparam int CW = $clog2(NUM_STAGES + 1);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_WAKE  = 2'd1,
    S_ON    = 2'd2,
    S_SLEEP = 2'd3
  } state_t;

  state_t                cur, nxt;
  logic [CW-1:0]         en_cnt, en_nxt;
  logic [DLY_W-1:0]      dly_cnt, dly_nxt, dly_load;
  logic [NUM_STAGES-1:0] therm_nxt;
  logic                  expired;
  logic                  step_ok;
  logic                  acks_all;

  // A programmed delay of zero still spaces segments by one cycle
  assign dly_load = (stage_delay == '0) ? DLY_W'(1) : stage_delay;
  // Counter reaching its last cycle (or parked at 0 waiting for an ack)
  assign expired  = (dly_cnt <= DLY_W'(1));

`ifdef PSW_ACK_EN
  // Wake steps wait for the most recently enabled segment to report on
  assign step_ok  = sw_ack[en_cnt - CW'(1)];
  assign acks_all = &sw_ack;
`else
  assign step_ok  = 1'b1;
  assign acks_all = 1'b1;
`endif

  assign state = cur;

  // Next-state, segment count and delay counter decisions
  always_comb begin
    nxt     = cur;
    en_nxt  = en_cnt;
    dly_nxt = dly_cnt;
    case (cur)
      S_OFF: begin
        en_nxt  = '0;
        dly_nxt = '0;
        if (!sleep_req) begin
          nxt     = S_WAKE;
          en_nxt  = CW'(1);
          dly_nxt = dly_load;
        end
      end
      S_WAKE: begin
        if (sleep_req) begin
          // Reversal: direction flips, segment count holds
          nxt     = S_SLEEP;
          dly_nxt = dly_load;
        end else if (expired && step_ok) begin
          if (en_cnt < CW'(NUM_STAGES)) begin
            en_nxt  = en_cnt + CW'(1);
            dly_nxt = dly_load;
          end else begin
            nxt     = S_ON;
            dly_nxt = '0;
          end
        end else if (expired) begin
          dly_nxt = '0;
        end else begin
          dly_nxt = dly_cnt - DLY_W'(1);
        end
      end
      S_ON: begin
        dly_nxt = '0;
        if (sleep_req) begin
          en_nxt = en_cnt - CW'(1);
          if (en_cnt <= CW'(1)) begin
            nxt    = S_OFF;
            en_nxt = '0;
          end else begin
            nxt     = S_SLEEP;
            dly_nxt = dly_load;
          end
        end
      end
      S_SLEEP: begin
        if (!sleep_req) begin
          nxt     = S_WAKE;
          dly_nxt = dly_load;
          if (en_cnt == '0) en_nxt = CW'(1);
        end else if (expired) begin
          if (en_cnt <= CW'(1)) begin
            nxt     = S_OFF;
            en_nxt  = '0;
            dly_nxt = '0;
          end else begin
            en_nxt  = en_cnt - CW'(1);
            dly_nxt = dly_load;
          end
        end else begin
          dly_nxt = dly_cnt - DLY_W'(1);
        end
      end
      default: begin
        nxt     = S_OFF;
        en_nxt  = '0;
        dly_nxt = '0;
      end
    endcase
  end

  // Thermometer code of the next segment count: bits below en_nxt conduct
  always_comb begin
    therm_nxt = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      therm_nxt[i] = (en_nxt > CW'(i));
    end
  end

  // State register with registered outputs; reset drops every segment at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= S_OFF;
      en_cnt     <= '0;
      dly_cnt    <= '0;
      switch_en  <= '0;
      power_good <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cur        <= nxt;
      en_cnt     <= en_nxt;
      dly_cnt    <= dly_nxt;
      switch_en  <= therm_nxt;
      power_good <= (nxt == S_ON) && acks_all;
      busy       <= (nxt == S_WAKE) || (nxt == S_SLEEP);
    end
  end

endmodule
